// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl -- UART receive frame controller.
//
// Walks a frame of start bit, 8 data bits (LSB first), an optional parity bit
// and a stop bit. The per-bit clock index goes out to an external data
// sampler; the sampler's majority-voted bit is consumed on the last clock of
// each bit. Frame settings are captured when a frame starts, so changes on
// the setting inputs mid-frame have no effect.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous reset, active high
//   rx_in        serial line, idle high
//   prescale     clocks per bit (8, 16 or 32; anything else runs as 8)
//   par_en       parity bit present in the frame
//   par_typ      parity type: 0 = even, 1 = odd
//   sampled_bit  majority-voted bit from the data sampler
//   dat_samp_en  sampler enable, high while a frame bit is being received
//   edge_count   clock index within the current bit
//   p_data       received byte
//   data_valid   one-cycle pulse marking a byte with no parity or stop error
//   par_err      parity error flag of the most recent frame
//   stp_err      stop-bit error flag of the most recent frame
// ---------------------------------------------------------------------------
module uart_rx_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic [5:0] prescale,
    input  logic       par_en,
    input  logic       par_typ,
    input  logic       sampled_bit,
    output logic       dat_samp_en,
    output logic [5:0] edge_count,
    output logic [7:0] p_data,
    output logic       data_valid,
    output logic       par_err,
    output logic       stp_err
);

    localparam int unsigned CNT_W  = 6;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned BIT_W  = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_edge_count;
    logic [BIT_W-1:0]    r_bit_count;
    logic [CNT_W-1:0]    r_pre;
    logic                r_par_en;
    logic                r_par_typ;
    logic [DATA_W-1:0]   r_p_data;
    logic                r_par_err;
    logic                r_stp_err;
    logic                r_data_valid;
    logic                r_dat_samp_en;

    state_t              w_next_state;
    logic [CNT_W-1:0]    w_edge_count;
    logic [BIT_W-1:0]    w_bit_count;
    logic [CNT_W-1:0]    w_pre;
    logic [CNT_W-1:0]    w_pre_eff;
    logic                w_par_en;
    logic                w_par_typ;
    logic [DATA_W-1:0]   w_p_data;
    logic                w_par_err;
    logic                w_stp_err;
    logic                w_data_valid;
    logic                w_dat_samp_en;
    logic                w_active;
    logic                w_bit_end;
    logic                w_start;

    // State register and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_edge_count  <= '0;
            r_bit_count   <= '0;
            r_pre         <= CNT_W'(8);
            r_par_en      <= 1'b0;
            r_par_typ     <= 1'b0;
            r_p_data      <= '0;
            r_par_err     <= 1'b0;
            r_stp_err     <= 1'b0;
            r_data_valid  <= 1'b0;
            r_dat_samp_en <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_edge_count  <= w_edge_count;
            r_bit_count   <= w_bit_count;
            r_pre         <= w_pre;
            r_par_en      <= w_par_en;
            r_par_typ     <= w_par_typ;
            r_p_data      <= w_p_data;
            r_par_err     <= w_par_err;
            r_stp_err     <= w_stp_err;
            r_data_valid  <= w_data_valid;
            r_dat_samp_en <= w_dat_samp_en;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        w_next_state = r_state;
        w_edge_count = '0;
        w_bit_count  = r_bit_count;
        w_pre        = r_pre;
        w_par_en     = r_par_en;
        w_par_typ    = r_par_typ;
        w_p_data     = r_p_data;
        w_par_err    = r_par_err;
        w_stp_err    = r_stp_err;
        w_start      = 1'b0;

        // Unsupported rates fall back to the slowest-sampled legal rate
        w_pre_eff = CNT_W'(8);
        if (prescale == CNT_W'(16) || prescale == CNT_W'(32)) begin
            w_pre_eff = prescale;
        end

        w_active  = (r_state == START) || (r_state == DATA) ||
                    (r_state == PARITY) || (r_state == STOP);
        w_bit_end = w_active && (r_edge_count == (r_pre - CNT_W'(1)));

        case (r_state)
            IDLE: begin
                if (!rx_in) begin
                    w_start = 1'b1;
                end
            end
            START: begin
                // A high start bit at its end means the falling edge was a glitch
                if (w_bit_end) begin
                    w_next_state = sampled_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_p_data[r_bit_count] = sampled_bit;
                    w_bit_count           = r_bit_count + BIT_W'(1);
                    if (r_bit_count == BIT_W'(7)) begin
                        w_next_state = r_par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_par_err    = sampled_bit != ((^r_p_data) ^ r_par_typ);
                    w_next_state = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_stp_err    = ~sampled_bit;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                // A low line here is the start bit of a back-to-back frame
                if (!rx_in) begin
                    w_start = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        // Frame start: capture settings and clear the previous frame's flags
        if (w_start) begin
            w_next_state = START;
            w_pre        = w_pre_eff;
            w_par_en     = par_en;
            w_par_typ    = par_typ;
            w_par_err    = 1'b0;
            w_stp_err    = 1'b0;
            w_bit_count  = '0;
        end

        // Bit clock index runs only inside a frame bit and wraps at bit end
        if (w_active && !w_bit_end) begin
            w_edge_count = r_edge_count + CNT_W'(1);
        end

        w_dat_samp_en = (w_next_state == START) || (w_next_state == DATA) ||
                        (w_next_state == PARITY) || (w_next_state == STOP);
        w_data_valid  = (w_next_state == DONE) && !w_par_err && !w_stp_err;
    end

    assign dat_samp_en = r_dat_samp_en;
    assign edge_count  = r_edge_count;
    assign p_data      = r_p_data;
    assign data_valid  = r_data_valid;
    assign par_err     = r_par_err;
    assign stp_err     = r_stp_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl -- self-checking bench for uart_rx_ctrl.
//
// The bench plays both the serial line and the data sampler. Each frame it
// sends is also queued as a descriptor (start cycle, rate, bit list); the
// compare process derives every output on every cycle from the offset into
// the active frame using plain arithmetic on that descriptor.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    logic       clk         = 1'b0;
    logic       rst         = 1'b1;
    logic       rx_in       = 1'b1;
    logic [5:0] prescale    = 6'd8;
    logic       par_en      = 1'b0;
    logic       par_typ     = 1'b0;
    logic       sampled_bit = 1'b1;
    logic       dat_samp_en;
    logic [5:0] edge_count;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .prescale    (prescale),
        .par_en      (par_en),
        .par_typ     (par_typ),
        .sampled_bit (sampled_bit),
        .dat_samp_en (dat_samp_en),
        .edge_count  (edge_count),
        .p_data      (p_data),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, a, e, cyc);
        end
    endfunction

    // Frame descriptor: bits[i] is what the sampler reports for frame bit i
    typedef struct {
        int          c;
        int          p;
        int          len;
        bit          pe;
        bit          pt;
        logic [10:0] bits;
    } frame_t;

    frame_t     q[$];
    frame_t     cur;
    bit         act     = 1'b0;
    logic [7:0] m_pdata = 8'h00;
    bit         m_perr  = 1'b0;
    bit         m_serr  = 1'b0;
    int         dv_cnt  = 0;
    int         last_dv = -1;
    int         prev_dv = -1;

    // Reference model and per-cycle compare
    always @(negedge clk) begin : cmp
        int         o;
        int         k;
        logic       exp_en;
        logic       exp_dv;
        logic [5:0] exp_ec;
        exp_en = 1'b0;
        exp_dv = 1'b0;
        exp_ec = 6'd0;
        if (data_valid === 1'b1) begin
            dv_cnt++;
            prev_dv = last_dv;
            last_dv = cyc;
        end
        if (rst) begin
            act = 1'b0;
            q.delete();
            m_pdata = 8'h00;
            m_perr  = 1'b0;
            m_serr  = 1'b0;
        end else begin
            if (act) begin
                o = cyc - cur.c;
                if (o == 1) begin
                    m_perr = 1'b0;
                    m_serr = 1'b0;
                end
                // Effect of frame bit k becomes visible one cycle after its last clock
                if (o >= 2 && ((o - 1) % cur.p) == 0) begin
                    k = (o - 1) / cur.p - 1;
                    if (k >= 1 && k <= 8) begin
                        m_pdata[3'(k - 1)] = cur.bits[4'(k)];
                    end else if (k == 9 && cur.pe) begin
                        m_perr = ((($countones(m_pdata) + int'(cur.bits[9])) % 2) != int'(cur.pt));
                    end
                    if (k == cur.len - 1 && cur.len > 1) begin
                        m_serr = ~cur.bits[4'(k)];
                    end
                end
                if (o >= 1 && o <= cur.len * cur.p) begin
                    exp_en = 1'b1;
                    exp_ec = 6'((o - 1) % cur.p);
                end
                if (o == cur.len * cur.p + 1) begin
                    if (cur.len > 1) exp_dv = !m_perr && !m_serr;
                    act = 1'b0;
                end
            end
            if (q.size() > 0 && q[0].c == cyc) begin
                cur = q.pop_front();
                act = 1'b1;
            end
        end
        chk("dat_samp_en", 32'(dat_samp_en), 32'(exp_en));
        chk("edge_count",  32'(edge_count),  32'(exp_ec));
        chk("data_valid",  32'(data_valid),  32'(exp_dv));
        chk("p_data",      32'(p_data),      32'(m_pdata));
        chk("par_err",     32'(par_err),     32'(m_perr));
        chk("stp_err",     32'(stp_err),     32'(m_serr));
    end

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rx_in       = 1'b1;
            sampled_bit = 1'($urandom);
            prescale    = 6'($urandom);
            par_en      = 1'($urandom);
            par_typ     = 1'($urandom);
        end
    endtask

    // kind: 0 good, 1 bad parity bit, 2 stop bit low, 3 start glitch.
    // Starts in the current cycle; returns in the DONE (or post-glitch IDLE) cycle.
    task automatic send_frame(input logic [5:0] p_in, input bit pe, input bit pt,
                              input logic [7:0] d, input int kind, input int rst_at,
                              output int c_out);
        frame_t f;
        int     p;
        p = (p_in == 6'd8 || p_in == 6'd16 || p_in == 6'd32) ? int'(p_in) : 8;
        f.c    = cyc;
        f.p    = p;
        f.pe   = pe;
        f.pt   = pt;
        f.bits = '1;
        f.bits[0]   = (kind == 3);
        f.bits[8:1] = d;
        if (pe) f.bits[9] = (^d) ^ pt ^ (kind == 1);
        if (kind == 2) f.bits[4'(9 + int'(pe))] = 1'b0;
        f.len = (kind == 3) ? 1 : 10 + int'(pe);
        q.push_back(f);
        c_out       = f.c;
        rx_in       = 1'b0;
        prescale    = p_in;
        par_en      = pe;
        par_typ     = pt;
        sampled_bit = 1'($urandom);
        for (int o = 1; o <= f.len * p; o++) begin
            @(posedge clk);
            #1;
            if (o == rst_at) begin
                #1;
                rst   = 1'b1;
                rx_in = 1'b1;
                #1;
                chk("rst_now dat_samp_en", 32'(dat_samp_en), 32'd0);
                chk("rst_now edge_count",  32'(edge_count),  32'd0);
                chk("rst_now p_data",      32'(p_data),      32'd0);
                chk("rst_now data_valid",  32'(data_valid),  32'd0);
                return;
            end
            sampled_bit = f.bits[4'((o - 1) / p)];
            rx_in       = (kind == 3) ? (o >= 2) : f.bits[4'((o - 1) / p)];
            prescale    = 6'($urandom);
            par_en      = 1'($urandom);
            par_typ     = 1'($urandom);
        end
        @(posedge clk);
        #1;
        rx_in       = 1'b1;
        sampled_bit = 1'($urandom);
    endtask

    initial begin
        #900000;
        total++;
        bad++;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int         c;
        int         c2;
        int         n0;
        int         kind;
        int         r;
        logic [5:0] pin;
        bit         pe;

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        at_neg();
        chk("reset p_data",      32'(p_data),      32'd0);
        chk("reset dat_samp_en", 32'(dat_samp_en), 32'd0);
        chk("reset flags",       32'({par_err, stp_err, data_valid}), 32'd0);
        idle(2);

        // 0xA5 at 8 clocks/bit, no parity
        n0 = dv_cnt;
        send_frame(6'd8, 1'b0, 1'b0, 8'hA5, 0, -1, c);
        at_neg();
        chk("a5 latency", 32'(last_dv - c), 32'd81);
        chk("a5 p_data",  32'(p_data),      32'hA5);
        chk("a5 dv_cnt",  32'(dv_cnt),      32'(n0 + 1));
        chk("a5 flags",   32'({par_err, stp_err}), 32'd0);

        // Even parity, parity bit wrong
        idle(3);
        n0 = dv_cnt;
        send_frame(6'd16, 1'b1, 1'b0, 8'h03, 1, -1, c);
        at_neg();
        chk("par par_err", 32'(par_err), 32'd1);
        chk("par p_data",  32'(p_data),  32'h03);
        chk("par dv_cnt",  32'(dv_cnt),  32'(n0));

        // Stop bit low, flag holds in IDLE, next good frame clears it
        idle(2);
        n0 = dv_cnt;
        send_frame(6'd8, 1'b0, 1'b0, 8'h5A, 2, -1, c);
        at_neg();
        chk("stop stp_err", 32'(stp_err), 32'd1);
        chk("stop dv_cnt",  32'(dv_cnt),  32'(n0));
        idle(4);
        at_neg();
        chk("stop hold", 32'(stp_err), 32'd1);
        idle(1);
        send_frame(6'd8, 1'b0, 1'b0, 8'hC3, 0, -1, c);
        at_neg();
        chk("stop cleared", 32'(stp_err), 32'd0);
        chk("stop next dv", 32'(dv_cnt),  32'(n0 + 1));

        // Start-bit glitch
        idle(2);
        n0 = dv_cnt;
        send_frame(6'd8, 1'b0, 1'b0, 8'h00, 3, -1, c);
        at_neg();
        chk("glitch dat_samp_en", 32'(dat_samp_en), 32'd0);
        chk("glitch flags",       32'({par_err, stp_err}), 32'd0);
        chk("glitch dv_cnt",      32'(dv_cnt), 32'(n0));
        chk("glitch p_data",      32'(p_data), 32'hC3);

        // Back-to-back frames at 32 clocks/bit
        idle(2);
        n0 = dv_cnt;
        send_frame(6'd32, 1'b0, 1'b0, 8'h55, 0, -1, c);
        send_frame(6'd32, 1'b0, 1'b0, 8'hFF, 0, -1, c2);
        at_neg();
        chk("b2b spacing", 32'(last_dv - prev_dv), 32'd321);
        chk("b2b dv_cnt",  32'(dv_cnt), 32'(n0 + 2));
        chk("b2b p_data",  32'(p_data), 32'hFF);

        // Reset during data bit 4, then a good frame with odd parity
        idle(2);
        n0 = dv_cnt;
        send_frame(6'd8, 1'b0, 1'b0, 8'hB7, 0, 5 * 8 + 3, c);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        idle(1);
        send_frame(6'd8, 1'b1, 1'b1, 8'h3C, 0, -1, c);
        at_neg();
        chk("post-rst p_data", 32'(p_data),  32'h3C);
        chk("post-rst dv_cnt", 32'(dv_cnt),  32'(n0 + 1));
        chk("post-rst par",    32'(par_err), 32'd0);

        // Randomised frames
        idle(2);
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 2)      pin = 6'd8;
            else if (r <= 5) pin = 6'd16;
            else if (r <= 7) pin = 6'd32;
            else             pin = 6'($urandom);
            pe   = 1'($urandom);
            kind = $urandom_range(0, 9);
            if (kind >= 4 && kind != 7 && kind != 8) kind = 0;
            else if (kind == 7) kind = 2;
            else if (kind == 8) kind = 3;
            else if (kind != 1) kind = 0;
            send_frame(pin, pe, 1'($urandom), 8'($urandom), kind, -1, c);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 5));
        end

        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-003 SHALL have port rx_in, input, 1, serial line, idle high.
REQ-004 SHALL have port prescale, input, 6, clocks per bit; legal values 8, 16, 32.
REQ-005 SHALL have port par_en, input, 1, 1 = parity bit present in frame.
REQ-006 SHALL have port par_typ, input, 1, 0 = even, 1 = odd.
REQ-007 SHALL have port sampled_bit, input, 1, majority-voted bit from the data sampler.
REQ-008 SHALL have port dat_samp_en, output, 1, enable to the data sampler.
REQ-009 SHALL have port edge_count, output, 6, clock index within the current bit, fed to the sampler.
REQ-010 SHALL have port p_data, output, 8, received byte.
REQ-011 SHALL have port data_valid, output, 1, one-cycle pulse marking a good byte.
REQ-012 SHALL have port par_err, output, 1, parity error flag.
REQ-013 SHALL have port stp_err, output, 1, stop-bit error flag.

Function
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, DONE.
REQ-015 In IDLE, SHALL move to START on rx_in==0, with edge_count=0 and bit_count=0 on entry.
REQ-016 SHALL latch prescale, par_en and par_typ on the IDLE->START transition; input changes mid-frame SHALL be ignored.
REQ-017 SHALL treat a latched prescale outside {8,16,32} as 8.
REQ-018 In START, DATA, PARITY and STOP, edge_count SHALL increment every cycle and wrap to 0 after the latched prescale-1.
REQ-019 edge_count SHALL be 0 in IDLE and DONE.
REQ-020 dat_samp_en SHALL be 1 exactly in START, DATA, PARITY and STOP.
REQ-021 SHALL consume sampled_bit only in the cycle where edge_count==prescale-1 (the bit end).
REQ-022 START bit end: sampled_bit==1 is a glitch and SHALL go to IDLE with no flags set; otherwise SHALL go to DATA.
REQ-023 DATA bit end: SHALL write p_data[bit_count]=sampled_bit (LSB first) and increment the 3-bit bit_count.
REQ-024 After bit 7, SHALL go to PARITY if par_en, else to STOP.
REQ-025 PARITY bit end: par_err SHALL be set to (sampled_bit != ^p_data XOR par_typ), then the state SHALL go to STOP.
REQ-026 STOP bit end: stp_err SHALL be set to (sampled_bit==0), then the state SHALL go to DONE.
REQ-027 DONE SHALL last exactly 1 cycle; data_valid SHALL be 1 in that cycle iff par_err==0 and stp_err==0.
REQ-028 From DONE, SHALL go to START if rx_in==0 (back-to-back frame), else to IDLE.
REQ-029 par_err and stp_err SHALL clear on the IDLE->START or DONE->START transition.
REQ-030 par_err and stp_err SHALL otherwise hold through DONE and IDLE.
REQ-031 p_data SHALL hold its value until overwritten bit by bit in the next frame.
REQ-032 Frame latency SHALL be from the rx_in falling edge seen in IDLE to data_valid = (10 + par_en) x prescale + 1 cycles.

Reset
REQ-033 While rst==1, SHALL force state IDLE, bit_count=0, edge_count=0, and p_data, data_valid, par_err, stp_err, dat_samp_en all 0.
REQ-034 rst SHALL take effect immediately and asynchronously in any state, including mid-frame; the partial frame SHALL be discarded with no data_valid.

Verification
REQ-035 prescale=8, par_en=0, frame 0xA5 -> p_data=0xA5, data_valid pulse at cycle 81, par_err=0, stp_err=0.
REQ-036 prescale=16, par_en=1, par_typ=0, byte 0x03 with parity bit 1 -> par_err=1, data_valid not asserted, p_data=0x03.
REQ-037 prescale=8, stop bit driven 0 -> stp_err=1, no data_valid; the next good frame clears stp_err.
REQ-038 rx_in low for 2 cycles only (sampler returns 1 at start bit end) -> back to IDLE, dat_samp_en=0, no flags set.
REQ-039 Two back-to-back frames 0x55 then 0xFF at prescale=32 -> two data_valid pulses, 321 cycles apart.
REQ-040 rst asserted during DATA bit 4 -> outputs 0 in the same cycle; after release the next frame is received correctly.
